serial_tx_arbiter: RTL and testbench

Shares one SerialTransciever among NREQ word producers. Arbitrates round-robin, latches the winner's word, and sequences the transmitter's Sample / StartTx handshake. Waits for transmit completion, then acknowledges the requester. Sits between producer blocks and the transmitter in the Clk domain; TxBusy/TxDone come back from the ClkTx domain and are synchronized internally.

---
 rtl/serial_tx_pkg.sv | 22 ++
 rtl/tx_status_sync.sv | 35 +++
 rtl/serial_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and defaults for the serial transmit arbiter.
// Provides the FSM state encoding and the requester-ID width helper.
package serial_tx_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    DONE
  } tx_state_t;

  // Bits needed to index n requesters; never less than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_status_sync.sv
// Brings the transmitter's TxBusy/TxDone status into the Clk domain.
// TxBusy is passed on as a level; TxDone is reduced to a one-cycle rising-edge pulse.
module tx_status_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic TxBusy,
  input  logic TxDone,
  output logic busy_sync,
  output logic done_evt
);

  logic busy_s1, busy_s2;
  logic done_s1, done_s2, done_s3;

  // done_s3 holds the previous synchronized TxDone for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_s3 <= 1'b0;
    end else begin
      busy_s1 <= TxBusy;
      busy_s2 <= busy_s1;
      done_s1 <= TxDone;
      done_s2 <= done_s1;
      done_s3 <= done_s2;
    end
  end

  assign busy_sync = busy_s2;
  assign done_evt  = done_s2 & ~done_s3;

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among NREQ word producers.
// Latches the winning word, runs the Sample/StartTx handshake, and acks on completion or timeout.
module serial_tx_arbiter
  import serial_tx_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int IDW    = id_width(NREQ)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       ReqValid,
  input  logic [NREQ*WIDTH-1:0] ReqData,
  output logic [NREQ-1:0]       ReqAck,
  output logic                  ReqErr,
  output logic [WIDTH-1:0]      TxData,
  output logic                  TxSample,
  output logic                  TxStartTx,
  input  logic                  TxBusy,
  input  logic                  TxDone,
  output logic [IDW-1:0]        ActiveId,
  output logic                  Busy
);

  localparam int CNTW = $clog2(TIMEOUT);

  tx_state_t        state, state_next;
  logic [IDW-1:0]   rr_ptr;
  logic [CNTW-1:0]  count;
  logic             err_q;

  logic             busy_sync, done_evt;
  logic             timed_out;

  logic             hi_found, lo_found, grant_found;
  logic [IDW-1:0]   hi_id, lo_id, grant_id;
  logic [WIDTH-1:0] grant_data;

  logic             load_grant;
  logic             done_err;

  tx_status_sync u_sync (
    .Clk       (Clk),
    .Reset     (Reset),
    .TxBusy    (TxBusy),
    .TxDone    (TxDone),
    .busy_sync (busy_sync),
    .done_evt  (done_evt)
  );

  // Lowest set index above the pointer wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (ReqValid[i]) begin
        if (IDW'(i) > rr_ptr) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end else begin
          lo_found = 1'b1;
          lo_id    = IDW'(i);
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_id    = hi_found ? hi_id : lo_id;
    grant_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        grant_data = ReqData[i*WIDTH +: WIDTH];
      end
    end
  end

  assign timed_out = (count == CNTW'(TIMEOUT - 1));
  assign Busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    ReqAck     = '0;
    ReqErr     = 1'b0;
    TxSample   = 1'b0;
    TxStartTx  = 1'b0;
    load_grant = 1'b0;
    done_err   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          load_grant = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        TxSample   = 1'b1;
        state_next = START;
      end
      START: begin
        TxStartTx = 1'b1;
        if (timed_out) begin
          done_err   = 1'b1;
          state_next = DONE;
        end else if (busy_sync) begin
          state_next = WAIT;
        end
      end
      // A completion edge wins over a timeout landing on the same cycle.
      WAIT: begin
        if (done_evt) begin
          state_next = DONE;
        end else if (timed_out) begin
          done_err   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        ReqErr = err_q;
        for (int i = 0; i < NREQ; i++) begin
          ReqAck[i] = (ActiveId == IDW'(i));
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // err_q tracks the exit reason until DONE, then holds it for the ack cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      rr_ptr   <= IDW'(NREQ - 1);
      ActiveId <= '0;
      TxData   <= '0;
      err_q    <= 1'b0;
      count    <= '0;
    end else begin
      state <= state_next;
      if (load_grant) begin
        ActiveId <= grant_id;
        TxData   <= grant_data;
      end
      if (state != DONE) begin
        err_q <= done_err;
      end
      if (state == DONE) begin
        rr_ptr <= ActiveId;
      end
      if (state == LOAD) begin
        count <= '0;
      end else if ((state == START) || (state == WAIT)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed self-checking bench for serial_tx_arbiter (NREQ=4, WIDTH=32, TIMEOUT=16).
// Drives the transmitter status lines by hand and checks each step against hand-computed values.
module tb_serial_tx_arbiter;

  logic         Clk;
  logic         Reset;
  logic [3:0]   ReqValid;
  logic [127:0] ReqData;
  logic [3:0]   ReqAck;
  logic         ReqErr;
  logic [31:0]  TxData;
  logic         TxSample;
  logic         TxStartTx;
  logic         TxBusy;
  logic         TxDone;
  logic [1:0]   ActiveId;
  logic         Busy;

  logic [31:0]  words [4];
  int           errors;
  int           checks;

  assign ReqData = {words[3], words[2], words[1], words[0]};

  serial_tx_arbiter #(
    .WIDTH   (32),
    .NREQ    (4),
    .TIMEOUT (16)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ReqValid  (ReqValid),
    .ReqData   (ReqData),
    .ReqAck    (ReqAck),
    .ReqErr    (ReqErr),
    .TxData    (TxData),
    .TxSample  (TxSample),
    .TxStartTx (TxStartTx),
    .TxBusy    (TxBusy),
    .TxDone    (TxDone),
    .ActiveId  (ActiveId),
    .Busy      (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid);
    ReqValid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Serves one transfer end to end, checking grant, handshake and ack.
  task automatic serveOne(input int expId, input logic [31:0] expData, input bit holdDone, input string tag);
    int n;
    n = 0;
    while (TxSample !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checkOutput({tag, "_sample"}, TxSample, 1);
    checkOutput({tag, "_id"}, ActiveId, expId);
    checkOutput({tag, "_data"}, TxData, expData);
    step();
    checkOutput({tag, "_start"}, {TxSample, TxStartTx}, 2'b01);
    TxBusy = 1'b1;
    n = 0;
    while (TxStartTx !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    TxDone = 1'b1;
    n = 0;
    while (ReqAck === 4'b0000 && n < 20) begin
      step();
      n++;
    end
    checkOutput({tag, "_ack"}, ReqAck, 4'b0001 << expId);
    checkOutput({tag, "_err"}, ReqErr, 0);
    TxBusy = 1'b0;
    if (!holdDone) TxDone = 1'b0;
  endtask

  initial begin
    int n;
    int extra;
    errors   = 0;
    checks   = 0;
    Reset    = 1'b1;
    ReqValid = 4'b0000;
    TxBusy   = 1'b0;
    TxDone   = 1'b0;
    words[0] = 32'h0000_9999;
    words[1] = 32'h1111_AAAA;
    words[2] = 32'hDEAD_BEEF;
    words[3] = 32'h3333_CCCC;

    // Reset state
    step();
    step();
    checkOutput("rst_ack", ReqAck, 0);
    checkOutput("rst_outs", {ReqErr, TxSample, TxStartTx, Busy}, 4'b0000);
    checkOutput("rst_txdata", TxData, 0);
    checkOutput("rst_id", ActiveId, 0);
    Reset = 1'b0;

    // Single requester with exact timing
    applyStimulus(4'b0100);
    step();
    checkOutput("t1_load", {TxSample, TxStartTx, Busy}, 3'b101);
    checkOutput("t1_data", TxData, 32'hDEAD_BEEF);
    checkOutput("t1_id", ActiveId, 2);
    step();
    checkOutput("t1_start", {TxSample, TxStartTx}, 2'b01);
    TxBusy = 1'b1;
    step();
    checkOutput("t1_start_hold1", TxStartTx, 1);
    step();
    checkOutput("t1_start_hold2", TxStartTx, 1);
    step();
    checkOutput("t1_wait", {TxSample, TxStartTx, Busy}, 3'b001);
    TxDone = 1'b1;
    TxBusy = 1'b0;
    step();
    checkOutput("t1_noack1", ReqAck, 0);
    step();
    checkOutput("t1_noack2", ReqAck, 0);
    step();
    checkOutput("t1_ack", ReqAck, 4'b0100);
    checkOutput("t1_err", ReqErr, 0);
    checkOutput("t1_data_hold", TxData, 32'hDEAD_BEEF);
    applyStimulus(4'b0000);
    step();
    checkOutput("t1_ack_pulse", {ReqAck, Busy}, 5'b00000);
    TxDone = 1'b0;

    // All four from reset, served in order 0..3
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    words[2] = 32'h2222_BBBB;
    applyStimulus(4'b1111);
    serveOne(0, 32'h0000_9999, 1'b0, "t2_r0");
    applyStimulus(4'b1110);
    serveOne(1, 32'h1111_AAAA, 1'b0, "t2_r1");
    applyStimulus(4'b1100);
    serveOne(2, 32'h2222_BBBB, 1'b0, "t2_r2");
    applyStimulus(4'b1000);
    serveOne(3, 32'h3333_CCCC, 1'b0, "t2_r3");
    applyStimulus(4'b0000);
    extra = 0;
    repeat (6) begin
      step();
      if (ReqAck !== 4'b0000 || TxSample !== 1'b0) extra++;
    end
    checkOutput("t2_no_extra", extra, 0);

    // Fairness: 0 and 3 both held high alternate
    applyStimulus(4'b1001);
    serveOne(0, 32'h0000_9999, 1'b0, "t3_a");
    serveOne(3, 32'h3333_CCCC, 1'b0, "t3_b");
    serveOne(0, 32'h0000_9999, 1'b0, "t3_c");
    serveOne(3, 32'h3333_CCCC, 1'b0, "t3_d");

    // Timeout: TxBusy rises but TxDone never does
    applyStimulus(4'b0110);
    n = 0;
    while (TxSample !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checkOutput("t4_id", ActiveId, 1);
    step();
    checkOutput("t4_start", TxStartTx, 1);
    TxBusy = 1'b1;
    n = 0;
    while (ReqAck === 4'b0000 && n < 40) begin
      step();
      n++;
    end
    checkOutput("t4_latency", n, 16);
    checkOutput("t4_ack", ReqAck, 4'b0010);
    checkOutput("t4_err", ReqErr, 1);
    applyStimulus(4'b0100);
    TxBusy = 1'b0;
    serveOne(2, 32'h2222_BBBB, 1'b0, "t4_next");

    // Reset during WAIT
    applyStimulus(4'b1001);
    n = 0;
    while (TxSample !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checkOutput("t5_id", ActiveId, 3);
    step();
    TxBusy = 1'b1;
    n = 0;
    while (TxStartTx !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    checkOutput("t5_in_wait", Busy, 1);
    Reset = 1'b1;
    #1;
    checkOutput("t5_rst_outs", {ReqAck, ReqErr, TxSample, TxStartTx, Busy}, 8'h00);
    checkOutput("t5_rst_data", TxData, 0);
    checkOutput("t5_rst_id", ActiveId, 0);
    TxBusy = 1'b0;
    step();
    step();
    checkOutput("t5_rst_noack", ReqAck, 0);
    Reset = 1'b0;
    serveOne(0, 32'h0000_9999, 1'b0, "t5_after");
    applyStimulus(4'b1000);
    serveOne(3, 32'h3333_CCCC, 1'b1, "t5_r3");
    applyStimulus(4'b0010);

    // Stale TxDone held high into the next WAIT
    n = 0;
    while (TxSample !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checkOutput("t6_id", ActiveId, 1);
    step();
    TxBusy = 1'b1;
    n = 0;
    while (TxStartTx !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    extra = 0;
    repeat (4) begin
      step();
      if (ReqAck !== 4'b0000) extra++;
    end
    checkOutput("t6_no_early_ack", extra, 0);
    TxDone = 1'b0;
    step();
    step();
    TxDone = 1'b1;
    n = 0;
    while (ReqAck === 4'b0000 && n < 20) begin
      step();
      n++;
    end
    checkOutput("t6_ack", ReqAck, 4'b0010);
    checkOutput("t6_err", ReqErr, 0);
    TxDone = 1'b0;
    TxBusy = 1'b0;
    applyStimulus(4'b0000);
    step();
    step();
    checkOutput("t6_idle", Busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
